// File: rtl/iomem_pkg.sv
// Shared constants, FSM encoding and request payload for the iomem arbiter.
package iomem_pkg;

    localparam int unsigned IOMEM_AW = 32;
    localparam int unsigned IOMEM_DW = 32;
    localparam int unsigned IOMEM_SW = 4;

    localparam logic [IOMEM_DW-1:0] IOMEM_ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [IOMEM_SW-1:0] wstrb;
        logic [IOMEM_AW-1:0] addr;
        logic [IOMEM_DW-1:0] wdata;
    } iomem_req_t;

endpackage

// File: rtl/iomem_watchdog.sv
// Saturating per-transaction cycle counter; expire_c flags the last allowed cycle.
module iomem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_c
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            assign expire_c = 1'b0;
        end else begin : g_on
            localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

            logic [CW-1:0] count_q;

            always_ff @(posedge clk) begin
                if (reset || clear_i) begin
                    count_q <= '0;
                end else if (enable_i && (count_q != LIMIT)) begin
                    count_q <= count_q + CW'(1);
                end
            end

            // Fires in the cycle that would bring the count up to the limit.
            assign expire_c = enable_i && (count_q >= (LIMIT - CW'(1)));
        end
    endgenerate

endmodule

// File: rtl/iomem_arbiter.sv
// Two-master iomem arbiter: round-robin or fixed-priority grant, one transaction
// in flight, registered responses and a per-transaction timeout watchdog.
module iomem_arbiter
    import iomem_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [IOMEM_DW-1:0]  ERR_RDATA      = IOMEM_ERR_RDATA,
    parameter bit                   FIXED_PRIO     = 1'b0
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                m0_valid,
    output logic                m0_ready,
    input  logic [IOMEM_SW-1:0] m0_wstrb,
    input  logic [IOMEM_AW-1:0] m0_addr,
    input  logic [IOMEM_DW-1:0] m0_wdata,
    output logic [IOMEM_DW-1:0] m0_rdata,

    input  logic                m1_valid,
    output logic                m1_ready,
    input  logic [IOMEM_SW-1:0] m1_wstrb,
    input  logic [IOMEM_AW-1:0] m1_addr,
    input  logic [IOMEM_DW-1:0] m1_wdata,
    output logic [IOMEM_DW-1:0] m1_rdata,

    output logic                s_valid,
    input  logic                s_ready,
    output logic [IOMEM_SW-1:0] s_wstrb,
    output logic [IOMEM_AW-1:0] s_addr,
    output logic [IOMEM_DW-1:0] s_wdata,
    input  logic [IOMEM_DW-1:0] s_rdata,

    output logic                grant_id,
    output logic                timeout
);

    arb_state_e state_q;
    logic       last_grant_q;
    logic       pick_m1_c;
    logic       wd_expire_c;
    iomem_req_t win_req_c;

    // Winner selection among pending requests.
    always_comb begin
        pick_m1_c = m1_valid;
        if (m0_valid && m1_valid) begin
            pick_m1_c = FIXED_PRIO ? 1'b0 : ~last_grant_q;
        end
        win_req_c = pick_m1_c ? iomem_req_t'({m1_wstrb, m1_addr, m1_wdata})
                              : iomem_req_t'({m0_wstrb, m0_addr, m0_wdata});
    end

    iomem_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q != ST_BUSY),
        .enable_i (state_q == ST_BUSY),
        .expire_c (wd_expire_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id     <= 1'b0;
            s_valid      <= 1'b0;
            s_wstrb      <= '0;
            s_addr       <= '0;
            s_wdata      <= '0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            timeout      <= 1'b0;
        end else begin
            m0_ready <= 1'b0;
            m1_ready <= 1'b0;
            timeout  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m0_valid || m1_valid) begin
                        grant_id     <= pick_m1_c;
                        last_grant_q <= pick_m1_c;
                        s_wstrb      <= win_req_c.wstrb;
                        s_addr       <= win_req_c.addr;
                        s_wdata      <= win_req_c.wdata;
                        s_valid      <= 1'b1;
                        state_q      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // Target completion takes precedence over an expiring watchdog.
                    if (s_ready || wd_expire_c) begin
                        s_valid <= 1'b0;
                        timeout <= ~s_ready;
                        state_q <= ST_DONE;
                        if (grant_id) begin
                            m1_rdata <= s_ready ? s_rdata : ERR_RDATA;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= s_ready ? s_rdata : ERR_RDATA;
                            m0_ready <= 1'b1;
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Directed bench: instance a is round-robin, instance b fixed-priority; both time out at 4.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid, s_ready;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;

    logic        a_m0_ready, a_m1_ready, a_s_valid, a_grant, a_timeout;
    logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
    logic [3:0]  a_s_wstrb;
    logic        b_m0_ready, b_m1_ready, b_s_valid, b_grant, b_timeout;
    logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
    logic [3:0]  b_s_wstrb;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iomem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(a_m1_rdata),
        .s_valid(a_s_valid), .s_ready(s_ready), .s_wstrb(a_s_wstrb), .s_addr(a_s_addr),
        .s_wdata(a_s_wdata), .s_rdata(s_rdata),
        .grant_id(a_grant), .timeout(a_timeout)
    );

    iomem_arbiter #(.TIMEOUT_CYCLES(4), .ERR_RDATA(32'hDEAD_BEEF), .FIXED_PRIO(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_ready(s_ready), .s_wstrb(b_s_wstrb), .s_addr(b_s_addr),
        .s_wdata(b_s_wdata), .s_rdata(s_rdata),
        .grant_id(b_grant), .timeout(b_timeout)
    );

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
        s_ready  = 1'b0; s_rdata  = 32'h0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        n_vec++; if (a_s_valid !== 1'b0) begin n_err++; $display("FAIL rst_s_valid: got %0h want 0", a_s_valid); end
        n_vec++; if ({a_m0_ready, a_m1_ready} !== 2'b00) begin n_err++; $display("FAIL rst_ready: got %0h want 0", {a_m0_ready, a_m1_ready}); end
        n_vec++; if ({a_m0_rdata, a_m1_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %0h want 0", {a_m0_rdata, a_m1_rdata}); end
        n_vec++; if ({a_s_wstrb, a_s_addr, a_s_wdata} !== 68'h0) begin n_err++; $display("FAIL rst_s_bus: got %0h want 0", {a_s_wstrb, a_s_addr, a_s_wdata}); end
        n_vec++; if ({a_grant, a_timeout} !== 2'b00) begin n_err++; $display("FAIL rst_grant_to: got %0h want 0", {a_grant, a_timeout}); end
    endtask

    task automatic test_single_read();
        idle_inputs();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0300_0000; m0_wstrb = 4'h0;
        step();
        n_vec++; if (a_s_valid !== 1'b1) begin n_err++; $display("FAIL rd_s_valid: got %0h want 1", a_s_valid); end
        n_vec++; if (a_s_addr !== 32'h0300_0000) begin n_err++; $display("FAIL rd_s_addr: got %0h want 3000000", a_s_addr); end
        n_vec++; if (a_grant !== 1'b0) begin n_err++; $display("FAIL rd_grant: got %0h want 0", a_grant); end
        step();
        n_vec++; if (a_m0_ready !== 1'b0) begin n_err++; $display("FAIL rd_early_ready: got %0h want 0", a_m0_ready); end
        s_ready = 1'b1; s_rdata = 32'h0000_00A5;
        step();
        n_vec++; if (a_m0_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %0h want 1", a_m0_ready); end
        n_vec++; if (a_m0_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_rdata: got %0h want a5", a_m0_rdata); end
        n_vec++; if ({a_m1_ready, a_s_valid} !== 2'b00) begin n_err++; $display("FAIL rd_m1rdy_sval: got %0h want 0", {a_m1_ready, a_s_valid}); end
        m0_valid = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;
        step();
        n_vec++; if (a_m0_ready !== 1'b0) begin n_err++; $display("FAIL rd_pulse_end: got %0h want 0", a_m0_ready); end
        n_vec++; if (a_m0_rdata !== 32'h0000_00A5) begin n_err++; $display("FAIL rd_rdata_hold: got %0h want a5", a_m0_rdata); end
    endtask

    task automatic test_round_robin();
        logic        exp_g;
        logic [31:0] exp_rd;
        idle_inputs();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_g  = (i % 2) == 1;
            exp_rd = 32'hC0DE_0000 + 32'(i);
            step();
            n_vec++; if (a_grant !== exp_g) begin n_err++; $display("FAIL rr_grant%0d: got %0h want %0h", i, a_grant, exp_g); end
            n_vec++; if (a_s_addr !== (exp_g ? 32'h200 : 32'h100)) begin n_err++; $display("FAIL rr_addr%0d: got %0h", i, a_s_addr); end
            s_rdata = exp_rd;
            step();
            n_vec++; if ({a_m1_ready, a_m0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_ready%0d: got %0h want %0h", i, {a_m1_ready, a_m0_ready}, exp_g ? 2'b10 : 2'b01); end
            n_vec++; if ((exp_g ? a_m1_rdata : a_m0_rdata) !== exp_rd) begin n_err++; $display("FAIL rr_rdata%0d: got %0h want %0h", i, exp_g ? a_m1_rdata : a_m0_rdata, exp_rd); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_fixed_prio();
        idle_inputs();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready  = 1'b1; s_rdata = 32'h0000_0F00;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (b_grant !== 1'b0) begin n_err++; $display("FAIL fp_grant%0d: got %0h want 0", i, b_grant); end
            step();
            n_vec++; if ({b_m1_ready, b_m0_ready} !== 2'b01) begin n_err++; $display("FAIL fp_ready%0d: got %0h want 1", i, {b_m1_ready, b_m0_ready}); end
            if (i == 1) m0_valid = 1'b0;
            step();
        end
        step();
        n_vec++; if (b_grant !== 1'b1) begin n_err++; $display("FAIL fp_m1_grant: got %0h want 1", b_grant); end
        n_vec++; if (b_s_addr !== 32'h0000_0200) begin n_err++; $display("FAIL fp_m1_addr: got %0h want 200", b_s_addr); end
        step();
        n_vec++; if ({b_m1_ready, b_m0_ready} !== 2'b10) begin n_err++; $display("FAIL fp_m1_ready: got %0h want 2", {b_m1_ready, b_m0_ready}); end
        idle_inputs();
        step();
    endtask

    task automatic test_timeout();
        idle_inputs();
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0300_0004;
        step();
        step();
        step();
        step();
        n_vec++; if ({a_s_valid, a_timeout} !== 2'b10) begin n_err++; $display("FAIL to_before: got %0h want 2", {a_s_valid, a_timeout}); end
        step();
        n_vec++; if ({a_s_valid, a_timeout, a_m1_ready} !== 3'b011) begin n_err++; $display("FAIL to_abort: got %0h want 3", {a_s_valid, a_timeout, a_m1_ready}); end
        n_vec++; if (a_m1_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_rdata: got %0h want deadbeef", a_m1_rdata); end
        m1_valid = 1'b0;
        step();
        n_vec++; if ({a_timeout, a_m1_ready} !== 2'b00) begin n_err++; $display("FAIL to_pulse_end: got %0h want 0", {a_timeout, a_m1_ready}); end
        m0_valid = 1'b1; m0_addr = 32'h0300_0010; s_ready = 1'b1; s_rdata = 32'h0000_0055;
        step();
        n_vec++; if ({a_s_valid, a_grant} !== 2'b10) begin n_err++; $display("FAIL to_next_grant: got %0h want 2", {a_s_valid, a_grant}); end
        step();
        n_vec++; if ({a_m0_ready, a_timeout} !== 2'b10) begin n_err++; $display("FAIL to_next_ready: got %0h want 2", {a_m0_ready, a_timeout}); end
        n_vec++; if (a_m0_rdata !== 32'h0000_0055) begin n_err++; $display("FAIL to_next_rdata: got %0h want 55", a_m0_rdata); end
        n_vec++; if (a_m1_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_m1_hold: got %0h want deadbeef", a_m1_rdata); end
        idle_inputs();
        step();
    endtask

    task automatic test_expiry_race();
        idle_inputs();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0300_0020;
        step();
        step();
        step();
        step();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        step();
        n_vec++; if ({a_m0_ready, a_timeout} !== 2'b10) begin n_err++; $display("FAIL race_ready_to: got %0h want 2", {a_m0_ready, a_timeout}); end
        n_vec++; if (a_m0_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL race_rdata: got %0h want 12345678", a_m0_rdata); end
        idle_inputs();
        step();
        n_vec++; if (a_timeout !== 1'b0) begin n_err++; $display("FAIL race_to_after: got %0h want 0", a_timeout); end
    endtask

    task automatic test_reset_mid_busy();
        m1_valid = 1'b1; m1_wstrb = 4'hF; m1_addr = 32'h0300_0008; m1_wdata = 32'hCAFE_F00D;
        step();
        n_vec++; if ({a_s_valid, a_grant, a_s_wstrb} !== 6'h3F) begin n_err++; $display("FAIL mr_busy: got %0h want 3f", {a_s_valid, a_grant, a_s_wstrb}); end
        n_vec++; if (a_s_wdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL mr_wdata: got %0h want cafef00d", a_s_wdata); end
        reset = 1'b1;
        step();
        n_vec++; if ({a_s_valid, a_grant, a_timeout, a_m0_ready, a_m1_ready} !== 5'h0) begin n_err++; $display("FAIL mr_ctl: got %0h want 0", {a_s_valid, a_grant, a_timeout, a_m0_ready, a_m1_ready}); end
        n_vec++; if ({a_m0_rdata, a_m1_rdata} !== 64'h0) begin n_err++; $display("FAIL mr_rdata: got %0h want 0", {a_m0_rdata, a_m1_rdata}); end
        n_vec++; if ({a_s_wstrb, a_s_addr, a_s_wdata} !== 68'h0) begin n_err++; $display("FAIL mr_s_bus: got %0h want 0", {a_s_wstrb, a_s_addr, a_s_wdata}); end
        reset = 1'b0;
        m0_valid = 1'b1; m0_addr = 32'h0300_000C; m0_wstrb = 4'h0;
        step();
        n_vec++; if ({a_s_valid, a_grant} !== 2'b10) begin n_err++; $display("FAIL mr_first_grant: got %0h want 2", {a_s_valid, a_grant}); end
        n_vec++; if (a_s_addr !== 32'h0300_000C) begin n_err++; $display("FAIL mr_first_addr: got %0h want 300000c", a_s_addr); end
        s_ready = 1'b1; s_rdata = 32'h0000_0077;
        step();
        n_vec++; if ({a_m1_ready, a_m0_ready} !== 2'b01) begin n_err++; $display("FAIL mr_ready: got %0h want 1", {a_m1_ready, a_m0_ready}); end
        idle_inputs();
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_prio();
        test_timeout();
        test_expiry_race();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
